host_switch_ctrl: RTL and testbench
===================================

Name: host_switch_ctrl

Overview:
- Sequences the A/B host-CPU selection in the dual-CPU switch board.
- Consumes the command decoder's force_swi/com_swi pulse pair plus per-CPU heartbeat, power and reset status.
- Decides the host, drives a break-before-make guard on the output-bus enables, and auto-fails-over when the host CPU stops beating.
- Sole owner of the switch signal fed back to the command decoder.

Parameters:
- HB_TIMEOUT, 32'd50_000_000: cycles without a heartbeat edge before a CPU is declared dead.
- GUARD_CYCLES, 32'd1000: cycles both bus enables are held low during a changeover.
- HOLDOFF_CYCLES, 32'd5_000_000: post-switch window in which automatic failover is suppressed.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- force_swi  input  1  one-cycle command strobe
- com_swi  input  1  commanded host (0=A, 1=B), valid with force_swi
- hb_a  input  1  CPU A heartbeat; any toggle counts, synchronised upstream
- hb_b  input  1  CPU B heartbeat
- power_on_A  input  1  CPU A powered
- power_on_B  input  1  CPU B powered
- reset_A  input  1  CPU A held in reset
- reset_B  input  1  CPU B held in reset
- switch  output  1  current host (0=A, 1=B)
- tx_en_a  output  1  CPU A output-bus enable
- tx_en_b  output  1  CPU B output-bus enable
- busy  output  1  changeover in progress
- auto_swi_evt  output  1  one-cycle pulse when an automatic failover starts
- fault  output  1  both CPUs dead
- alive_a  output  1  CPU A health
- alive_b  output  1  CPU B health

Behaviour:
- Reset, applied at any time including mid-changeover, sets on the next edge: state ACTIVE, switch=0, tx_en_a=1, tx_en_b=0, busy=0, auto_swi_evt=0, fault=0, alive_a=1, alive_b=1, all counters 0, heartbeat edge registers loaded from hb_x.
- Watchdog, per CPU x:
  - 32-bit counter cleared on a heartbeat edge (hb_x differs from its registered copy) or while reset_x=1; otherwise increments and saturates at HB_TIMEOUT.
  - alive_x (registered) = power_on_x & (cnt_x < HB_TIMEOUT).
  - Power-off drops alive on the next edge.
- fault (registered) = ~alive_a & ~alive_b. It is informational and does not change state.
- Host enable: in ACTIVE/HOLDOFF, tx_en_a=~switch and tx_en_b=switch. In GUARD/COMMIT both are 0. The two enables are never simultaneously 1.
- ACTIVE:
  - force_swi & (com_swi != switch): target<=com_swi, go to GUARD, guard counter=0.
  - force_swi & (com_swi == switch): ignored.
  - Otherwise, if the host is dead and the other CPU is alive: target<=~switch, pulse auto_swi_evt, go to GUARD.
  - force_swi has priority over auto in the same cycle.
  - A force toward a dead or unpowered CPU is still honoured.
- GUARD:
  - Counts GUARD_CYCLES cycles, then goes to COMMIT.
  - force_swi here overwrites target with com_swi and does not restart the counter.
  - Heartbeat loss here is ignored.
- COMMIT, one cycle: switch<=target, go to HOLDOFF, holdoff counter=0. If target==switch (retracted by a force), the enables are restored without a flip.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES, then goes to ACTIVE.
  - Auto failover is suppressed; force_swi is handled exactly as in ACTIVE (re-enters GUARD).
- busy=1 exactly in GUARD and COMMIT.
- Latency: with force_swi sampled at edge t, the enables are 0 from t+1, switch flips at edge t+1+GUARD_CYCLES+1, and the new host enable rises at that same edge.
- All comparisons are unsigned 32-bit; counters never wrap.

Test Plan (HB_TIMEOUT=20, GUARD_CYCLES=4, HOLDOFF_CYCLES=10, both CPUs powered and toggling every 5 cycles):
- Reset, idle 50 cycles -> switch=0, tx_en_a=1, tx_en_b=0, alive_a=alive_b=1, fault=0, busy=0.
- force_swi=1, com_swi=1 at edge t -> tx_en_a=0 at t+1; busy=1 for 5 cycles; switch=1 and tx_en_b=1 at t+6; auto_swi_evt never asserted.
- Stop hb_a with host A -> alive_a=0 about 20 cycles later; auto_swi_evt pulses once; switch=1 after 5 more cycles.
- After that failover, stop hb_b inside HOLDOFF -> no switch until HOLDOFF ends. Then, with hb_a restarted, switch returns to 0; with hb_a still stopped, fault=1 and switch stays 1.
- force com_swi=1, then force com_swi=0 two cycles later in GUARD -> switch stays 0, tx_en_a returns to 1 at the original commit time, and the two enables are never both 1.
- Assert rst during GUARD -> next edge switch=0, tx_en_a=1, busy=0; power_on_A=0 -> alive_a=0 next edge, followed by auto failover to B.

Source files
------------

// File: rtl/host_switch_ctrl.sv
// Host CPU A/B selection: per-CPU heartbeat watchdogs, break-before-make bus
// enable sequencing, commanded switching and automatic failover.
module host_switch_ctrl #(
    parameter logic [31:0] HB_TIMEOUT     = 32'd50_000_000,
    parameter logic [31:0] GUARD_CYCLES   = 32'd1000,
    parameter logic [31:0] HOLDOFF_CYCLES = 32'd5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic force_swi,
    input  logic com_swi,
    input  logic hb_a,
    input  logic hb_b,
    input  logic power_on_A,
    input  logic power_on_B,
    input  logic reset_A,
    input  logic reset_B,
    output logic switch,
    output logic tx_en_a,
    output logic tx_en_b,
    output logic busy,
    output logic auto_swi_evt,
    output logic fault,
    output logic alive_a,
    output logic alive_b
);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_GUARD   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_switch;
    logic        r_target;
    logic        r_tx_en_a;
    logic        r_tx_en_b;
    logic        r_busy;
    logic        r_auto_evt;
    logic        r_fault;
    logic        r_alive_a;
    logic        r_alive_b;
    logic        r_hb_a_q;
    logic        r_hb_b_q;
    logic [31:0] r_cnt_a;
    logic [31:0] r_cnt_b;
    logic [31:0] r_guard_cnt;
    logic [31:0] r_hold_cnt;

    logic w_edge_a;
    logic w_edge_b;
    logic w_host_dead;
    logic w_other_alive;
    logic w_force_flip;

    assign w_edge_a      = hb_a ^ r_hb_a_q;
    assign w_edge_b      = hb_b ^ r_hb_b_q;
    assign w_host_dead   = r_switch ? ~r_alive_b : ~r_alive_a;
    assign w_other_alive = r_switch ? r_alive_a : r_alive_b;
    assign w_force_flip  = force_swi & (com_swi != r_switch);

    // Heartbeat watchdogs; counters saturate at the timeout so they never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_a_q  <= hb_a;
            r_hb_b_q  <= hb_b;
            r_cnt_a   <= 32'd0;
            r_cnt_b   <= 32'd0;
            r_alive_a <= 1'b1;
            r_alive_b <= 1'b1;
            r_fault   <= 1'b0;
        end else begin
            r_hb_a_q <= hb_a;
            r_hb_b_q <= hb_b;
            if (reset_A || w_edge_a) begin
                r_cnt_a <= 32'd0;
            end else if (r_cnt_a < HB_TIMEOUT) begin
                r_cnt_a <= r_cnt_a + 32'd1;
            end
            if (reset_B || w_edge_b) begin
                r_cnt_b <= 32'd0;
            end else if (r_cnt_b < HB_TIMEOUT) begin
                r_cnt_b <= r_cnt_b + 32'd1;
            end
            r_alive_a <= power_on_A & (r_cnt_a < HB_TIMEOUT);
            r_alive_b <= power_on_B & (r_cnt_b < HB_TIMEOUT);
            r_fault   <= ~r_alive_a & ~r_alive_b;
        end
    end

    // Changeover sequencer: both enables drop for the guard, then the new host is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACTIVE;
            r_switch    <= 1'b0;
            r_target    <= 1'b0;
            r_tx_en_a   <= 1'b1;
            r_tx_en_b   <= 1'b0;
            r_busy      <= 1'b0;
            r_auto_evt  <= 1'b0;
            r_guard_cnt <= 32'd0;
            r_hold_cnt  <= 32'd0;
        end else begin
            r_auto_evt <= 1'b0;
            case (r_state)
                ST_ACTIVE, ST_HOLDOFF: begin
                    if (w_force_flip) begin
                        r_target    <= com_swi;
                        r_state     <= ST_GUARD;
                        r_guard_cnt <= 32'd0;
                        r_tx_en_a   <= 1'b0;
                        r_tx_en_b   <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if ((r_state == ST_ACTIVE) && !force_swi
                                 && w_host_dead && w_other_alive) begin
                        r_target    <= ~r_switch;
                        r_auto_evt  <= 1'b1;
                        r_state     <= ST_GUARD;
                        r_guard_cnt <= 32'd0;
                        r_tx_en_a   <= 1'b0;
                        r_tx_en_b   <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (r_state == ST_HOLDOFF) begin
                        if (r_hold_cnt + 32'd1 >= HOLDOFF_CYCLES) begin
                            r_state <= ST_ACTIVE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 32'd1;
                        end
                    end
                end
                ST_GUARD: begin
                    if (force_swi) begin
                        r_target <= com_swi;
                    end
                    if (r_guard_cnt + 32'd1 >= GUARD_CYCLES) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 32'd1;
                    end
                end
                ST_COMMIT: begin
                    r_switch   <= r_target;
                    r_tx_en_a  <= ~r_target;
                    r_tx_en_b  <= r_target;
                    r_busy     <= 1'b0;
                    r_hold_cnt <= 32'd0;
                    r_state    <= ST_HOLDOFF;
                end
                default: r_state <= ST_ACTIVE;
            endcase
        end
    end

    assign switch       = r_switch;
    assign tx_en_a      = r_tx_en_a;
    assign tx_en_b      = r_tx_en_b;
    assign busy         = r_busy;
    assign auto_swi_evt = r_auto_evt;
    assign fault        = r_fault;
    assign alive_a      = r_alive_a;
    assign alive_b      = r_alive_b;

endmodule

// File: tb/tb_host_switch_ctrl.sv
// Directed and randomized bench for host_switch_ctrl against a timestamp-based reference model.
module tb_host_switch_ctrl;

    localparam logic [31:0] T_HB = 32'd20;
    localparam logic [31:0] T_G  = 32'd4;
    localparam logic [31:0] T_H  = 32'd10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, force_swi, com_swi, hb_a, hb_b;
    logic power_on_A, power_on_B, reset_A, reset_B;
    logic switch, tx_en_a, tx_en_b, busy, auto_swi_evt, fault, alive_a, alive_b;

    host_switch_ctrl #(
        .HB_TIMEOUT    (T_HB),
        .GUARD_CYCLES  (T_G),
        .HOLDOFF_CYCLES(T_H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .force_swi   (force_swi),
        .com_swi     (com_swi),
        .hb_a        (hb_a),
        .hb_b        (hb_b),
        .power_on_A  (power_on_A),
        .power_on_B  (power_on_B),
        .reset_A     (reset_A),
        .reset_B     (reset_B),
        .switch      (switch),
        .tx_en_a     (tx_en_a),
        .tx_en_b     (tx_en_b),
        .busy        (busy),
        .auto_swi_evt(auto_swi_evt),
        .fault       (fault),
        .alive_a     (alive_a),
        .alive_b     (alive_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: every event is an edge index; liveness and changeover
    // phases are derived from elapsed edges since the last relevant event.
    longint n = 0;
    longint clr_a = 0, clr_b = 0;
    longint commit_at = 0, hold_until = 0;
    logic   m_switch = 1'b0, m_target = 1'b0, m_changing = 1'b0;
    logic   m_evt = 1'b0, m_fault = 1'b0, m_alive_a = 1'b1, m_alive_b = 1'b1;
    logic   m_hb_a = 1'b0, m_hb_b = 1'b0;
    logic   na, nb, host_dead, other_alive;

    always @(posedge clk) begin
        n = n + 1;
        m_evt = 1'b0;
        if (rst) begin
            clr_a = n; clr_b = n; hold_until = n;
            m_switch = 1'b0; m_target = 1'b0; m_changing = 1'b0;
            m_fault = 1'b0; m_alive_a = 1'b1; m_alive_b = 1'b1;
        end else begin
            na = power_on_A && ((n - 1 - clr_a) < longint'(T_HB));
            nb = power_on_B && ((n - 1 - clr_b) < longint'(T_HB));
            m_fault = !m_alive_a && !m_alive_b;
            if (reset_A || (hb_a != m_hb_a)) clr_a = n;
            if (reset_B || (hb_b != m_hb_b)) clr_b = n;
            host_dead   = m_switch ? !m_alive_b : !m_alive_a;
            other_alive = m_switch ? m_alive_a : m_alive_b;
            if (m_changing) begin
                if (n == commit_at) begin
                    m_switch = m_target; m_changing = 1'b0; hold_until = n + longint'(T_H);
                end else if (force_swi) begin
                    m_target = com_swi;
                end
            end else if (force_swi && (com_swi != m_switch)) begin
                m_target = com_swi; m_changing = 1'b1; commit_at = n + longint'(T_G) + 1;
            end else if (!force_swi && (n > hold_until) && host_dead && other_alive) begin
                m_target = !m_switch; m_changing = 1'b1; commit_at = n + longint'(T_G) + 1;
                m_evt = 1'b1;
            end
            m_alive_a = na;
            m_alive_b = nb;
        end
        m_hb_a = hb_a;
        m_hb_b = hb_b;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        chk("switch", switch, m_switch);
        chk("tx_en_a", tx_en_a, !m_changing && !m_switch);
        chk("tx_en_b", tx_en_b, !m_changing && m_switch);
        chk("busy", busy, m_changing);
        chk("auto_swi_evt", auto_swi_evt, m_evt);
        chk("fault", fault, m_fault);
        chk("alive_a", alive_a, m_alive_a);
        chk("alive_b", alive_b, m_alive_b);
        chk("enables_exclusive", tx_en_a & tx_en_b, 1'b0);
    endtask

    int  tick = 0;
    bit  run_a = 1'b1, run_b = 1'b1;

    // One clock: sample at the falling edge, then advance heartbeats and drop the strobe.
    task automatic cyc();
        @(negedge clk);
        check_all();
        tick++;
        if (tick % 5 == 0) begin
            if (run_a) hb_a = ~hb_a;
            if (run_b) hb_b = ~hb_b;
        end
        force_swi = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    task automatic strobe(input logic c);
        force_swi = 1'b1;
        com_swi   = c;
        cyc();
    endtask

    int k;

    initial begin
        rst = 1'b1; force_swi = 1'b0; com_swi = 1'b0; hb_a = 1'b0; hb_b = 1'b0;
        power_on_A = 1'b1; power_on_B = 1'b1; reset_A = 1'b0; reset_B = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(50);
        chk("idle_switch", switch, 1'b0);
        chk("idle_tx_en_a", tx_en_a, 1'b1);
        chk("idle_tx_en_b", tx_en_b, 1'b0);
        chk("idle_alive_a", alive_a, 1'b1);
        chk("idle_alive_b", alive_b, 1'b1);
        chk("idle_fault", fault, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Commanded switch to B: five busy cycles, then B enabled.
        strobe(1'b1);
        chk("cmd_tx_en_a_off", tx_en_a, 1'b0);
        chk("cmd_busy_1", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("cmd_busy_hold", busy, 1'b1);
            chk("cmd_switch_hold", switch, 1'b0);
        end
        cyc();
        chk("cmd_switch_b", switch, 1'b1);
        chk("cmd_tx_en_b_on", tx_en_b, 1'b1);
        chk("cmd_busy_done", busy, 1'b0);
        idle(15);

        // Back to A, then starve A's heartbeat for an automatic failover.
        strobe(1'b0);
        idle(20);
        chk("back_on_a", switch, 1'b0);
        run_a = 1'b0;
        k = 0;
        while (auto_swi_evt !== 1'b1 && k < 60) begin cyc(); k++; end
        chk("auto_evt_seen", auto_swi_evt, 1'b1);
        chk("auto_evt_latency", (k >= 15) && (k <= 30), 1'b1);
        chk("auto_alive_a_low", alive_a, 1'b0);
        idle(4);
        chk("auto_switch_pending", switch, 1'b0);
        cyc();
        chk("auto_switch_b", switch, 1'b1);

        // Lose B inside holdoff with A restarted: return to A once holdoff is over.
        run_a = 1'b1;
        run_b = 1'b0;
        idle(9);
        chk("holdoff_no_switch", switch, 1'b1);
        k = 0;
        while (switch !== 1'b0 && k < 80) begin cyc(); k++; end
        chk("return_to_a", switch, 1'b0);

        // Host B with A dead, then B dies too: fault, no switch.
        run_b = 1'b1;
        idle(10);
        strobe(1'b1);
        idle(20);
        run_a = 1'b0;
        idle(30);
        chk("b_host_a_dead", alive_a, 1'b0);
        run_b = 1'b0;
        idle(40);
        chk("fault_both_dead", fault, 1'b1);
        chk("fault_switch_stays", switch, 1'b1);

        // Retracted command: switch stays A, A re-enabled at original commit time.
        run_a = 1'b1; run_b = 1'b1;
        idle(30);
        strobe(1'b0);
        idle(20);
        chk("retract_pre_a", switch, 1'b0);
        strobe(1'b1);
        cyc();
        strobe(1'b0);
        idle(2);
        chk("retract_guard_off", tx_en_a, 1'b0);
        cyc();
        chk("retract_tx_en_a", tx_en_a, 1'b1);
        chk("retract_switch", switch, 1'b0);
        idle(15);

        // Reset mid-guard, then power loss on A.
        strobe(1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_switch", switch, 1'b0);
        chk("rst_tx_en_a", tx_en_a, 1'b1);
        chk("rst_busy", busy, 1'b0);
        power_on_A = 1'b0;
        cyc();
        chk("poweroff_alive_a", alive_a, 1'b0);
        k = 0;
        while (switch !== 1'b1 && k < 15) begin cyc(); k++; end
        chk("poweroff_failover", switch, 1'b1);
        power_on_A = 1'b1;
        idle(20);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            force_swi = ($urandom_range(0, 15) == 0);
            com_swi   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) run_a = ~run_a;
            if ($urandom_range(0, 39) == 0) run_b = ~run_b;
            if ($urandom_range(0, 199) == 0) power_on_A = ~power_on_A;
            if ($urandom_range(0, 199) == 0) power_on_B = ~power_on_B;
            reset_A = ($urandom_range(0, 49) == 0);
            reset_B = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 799) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
